// File: rtl/reclock_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reclock_sched_pkg
//  Description : Shared types and limits for the reclocking update scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package reclock_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Supported parameter limits
    localparam int MAX_REQ  = 8;
    localparam int MAX_HOLD = 15;

endpackage
`default_nettype wire

// File: rtl/reclock_update_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search starts at the pointer and
//                wraps; the pointer moves past the winner only on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               j;

    assign grant_valid = |req;

    // First requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        grant_idx = ptr;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reclock_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reclock_update_sched
//  Description : Schedules requester updates into a shared reclocking bank:
//                one enable pulse with stable data, a hold gap, then a
//                one-cycle acknowledge to the served requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module reclock_update_sched
    import reclock_sched_pkg::*;
#(
    parameter int  NUM_REQ     = 2,
    parameter int  WIDTH       = 8,
    parameter int  HOLD_CYCLES = 2,
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     ena,
    output logic [WIDTH-1:0]         data_out,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    // Counter only ever holds HOLD_CYCLES-1 down to 0
    localparam int CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               advance;
    logic [NUM_REQ-1:0] ack_dec;

    // Requests are only looked at while idle
    assign advance = (state == IDLE) && grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rstb        (rstb),
        .req         (req),
        .advance     (advance),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // One-hot of the registered grant, used to register the ack pulse
    always_comb begin
        ack_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_dec[i] = (grant_id == IDX_W'(i));
        end
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ena      <= 1'b0;
            ack      <= '0;
            data_out <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            ena <= 1'b0;
            ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state    <= LOAD;
                        ena      <= 1'b1;
                        busy     <= 1'b1;
                        grant_id <= grant_idx;
                        data_out <= req_data[grant_idx*WIDTH +: WIDTH];
                    end
                end
                LOAD: begin
                    if (HOLD_CYCLES > 0) begin
                        state    <= HOLD;
                        hold_cnt <= CNT_W'(HOLD_LOAD);
                    end else begin
                        state <= ACK;
                        ack   <= ack_dec;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ACK;
                        ack   <= ack_dec;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reclock_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reclock_update_sched
//  Description : Self-checking bench. Two schedulers (hold gap 2 and 0) share
//                one stimulus stream and are compared every cycle against a
//                transaction-timeline model, plus directed corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reclock_update_sched;

    localparam int N = 2;
    localparam int W = 8;

    logic           clk  = 1'b0;
    logic           rstb = 1'b0;
    logic [N-1:0]   req  = '0;
    logic [N*W-1:0] req_data = '0;

    logic [N-1:0] ack_a, ack_b;
    logic         ena_a, ena_b;
    logic [W-1:0] dout_a, dout_b;
    logic         gid_a, gid_b;
    logic         busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    string tag = "reset";

    always #5 clk = ~clk;

    reclock_update_sched #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dut_a (
        .clk(clk), .rstb(rstb), .req(req), .req_data(req_data),
        .ack(ack_a), .ena(ena_a), .data_out(dout_a), .grant_id(gid_a), .busy(busy_a)
    );

    reclock_update_sched #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rstb(rstb), .req(req), .req_data(req_data),
        .ack(ack_b), .ena(ena_b), .data_out(dout_b), .grant_id(gid_b), .busy(busy_b)
    );

    // ---------------- reference model: transaction timeline ----------------
    // phase 0 = idle; phase 1 = enable cycle; phase 2+hold = ack cycle.
    int m_hold  [2] = '{2, 0};
    int m_phase [2];
    int m_ptr   [2];
    int m_gid   [2];
    int m_dout  [2];

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_ptr[d] = 0; m_gid[d] = 0; m_dout[d] = 0;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 0) begin
                if (|req) begin
                    w          = rr_pick(m_ptr[d], req);
                    m_ptr[d]   = (w + 1) % N;
                    m_gid[d]   = w;
                    m_dout[d]  = int'(req_data[w*W +: W]);
                    m_phase[d] = 1;
                end
            end else if (m_phase[d] == 2 + m_hold[d]) begin
                m_phase[d] = 0;
            end else begin
                m_phase[d] = m_phase[d] + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: actual %0h required %0h", name, tag, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_ena, e_busy, e_ack;
        for (int d = 0; d < 2; d++) begin
            e_ena  = (m_phase[d] == 1) ? 1 : 0;
            e_busy = (m_phase[d] != 0) ? 1 : 0;
            e_ack  = (m_phase[d] == 2 + m_hold[d]) ? (32'd1 << m_gid[d]) : 0;
            if (d == 0) begin
                check("a_ena", ena_a, e_ena);   check("a_busy", busy_a, e_busy);
                check("a_ack", ack_a, e_ack);   check("a_dout", dout_a, m_dout[0]);
                check("a_gid", gid_a, m_gid[0]);
            end else begin
                check("b_ena", ena_b, e_ena);   check("b_busy", busy_b, e_busy);
                check("b_ack", ack_b, e_ack);   check("b_dout", dout_b, m_dout[1]);
                check("b_gid", gid_b, m_gid[1]);
            end
        end
    endtask

    // One clock: model sees the same inputs the DUT sampled, compare at +1
    task automatic step();
        @(posedge clk);
        if (rstb) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        req  = '0;
        rstb = 1'b0;
        #1;
        model_reset();
        repeat (3) step();
        rstb = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        repeat (8) step();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  req;
        logic [15:0] data;
        logic        ena;
        logic [1:0]  ack;
        logic        busy;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl [6];
    int   n_ena, n_ack;
    int   ena_t [4];
    int   ena_d [4];
    int   ena_g [4];

    initial begin
        tbl[0] = '{2'b01, 16'h00A5, 1'b1, 2'b00, 1'b1, 8'hA5};
        tbl[1] = '{2'b01, 16'h00A5, 1'b0, 2'b00, 1'b1, 8'hA5};
        tbl[2] = '{2'b01, 16'h00A5, 1'b0, 2'b00, 1'b1, 8'hA5};
        tbl[3] = '{2'b01, 16'h00A5, 1'b0, 2'b01, 1'b1, 8'hA5};
        tbl[4] = '{2'b00, 16'h00A5, 1'b0, 2'b00, 1'b0, 8'hA5};
        tbl[5] = '{2'b00, 16'h00A5, 1'b0, 2'b00, 1'b0, 8'hA5};

        // 1. reset state, then single request
        model_reset();
        #2;
        check("rst_ena", ena_a, 0);  check("rst_busy", busy_a, 0);
        check("rst_ack", ack_a, 0);  check("rst_dout", dout_a, 0);
        check("rst_gid", gid_a, 0);
        do_reset();
        step();
        tag = "single";
        for (int i = 0; i < 6; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            step();
            check($sformatf("t1_ena_r%0d", i),  ena_a,  tbl[i].ena);
            check($sformatf("t1_ack_r%0d", i),  ack_a,  tbl[i].ack);
            check($sformatf("t1_busy_r%0d", i), busy_a, tbl[i].busy);
            check($sformatf("t1_dout_r%0d", i), dout_a, tbl[i].dout);
        end

        // 2. simultaneous contention from a fresh pointer
        tag = "contention";
        do_reset();
        req_data = 16'h2211;
        req      = 2'b11;
        n_ena    = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ena_a) begin
                if (n_ena < 4) begin ena_t[n_ena] = c; ena_d[n_ena] = int'(dout_a); end
                n_ena++;
            end
            req = req & ~ack_a;
        end
        check("cont_pulses", n_ena, 2);
        check("cont_first",  ena_d[0], 32'h11);
        check("cont_second", ena_d[1], 32'h22);
        check("cont_gap",    ena_t[1] - ena_t[0], 5);

        // 3. fairness: each requester re-raises right after its ack
        tag   = "fairness";
        n_ena = 0;
        for (int c = 0; c < 40; c++) begin
            req = 2'b11 & ~ack_a;
            step();
            if (ena_a) begin
                if (n_ena < 4) ena_g[n_ena] = int'(gid_a);
                n_ena++;
            end
        end
        req = 2'b11 & ~ack_a;
        check("fair_g0", ena_g[0], 0);
        check("fair_g1", ena_g[1], 1);
        check("fair_g2", ena_g[2], 0);
        check("fair_g3", ena_g[3], 1);
        drain();

        // 4. zero-hold build timing
        tag      = "nohold";
        req      = 2'b01;
        req_data = 16'h00A7;
        step();
        check("b_e1_ena", ena_b, 1);
        check("b_e1_dout", dout_b, 32'hA7);
        req = '0;
        step();
        check("b_e2_ack", ack_b, 2'b01);
        check("b_e2_ena", ena_b, 0);
        step();
        check("b_e3_busy", busy_b, 0);
        check("b_e3_ack", ack_b, 0);
        drain();

        // 5. one-cycle request still completes
        tag      = "early_drop";
        req      = 2'b10;
        req_data = 16'h5C00;
        step();
        check("drop_ena",  ena_a, 1);
        check("drop_dout", dout_a, 32'h5C);
        req   = '0;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack_a[1]) n_ack++;
        end
        check("drop_acks",      n_ack, 1);
        check("drop_idle_dout", dout_a, 32'h5C);
        check("drop_idle_busy", busy_a, 0);

        // 6. reset during hold
        tag      = "mid_reset";
        drain();
        req      = 2'b10;
        req_data = 16'h3C00;
        step();
        step();
        check("mr_in_hold", busy_a, 1);
        #2;
        rstb = 1'b0;
        #1;
        check("mr_ena",  ena_a, 0);  check("mr_busy", busy_a, 0);
        check("mr_ack",  ack_a, 0);  check("mr_dout", dout_a, 0);
        check("mr_gid",  gid_a, 0);
        model_reset();
        n_ack = 0;
        repeat (2) begin step(); if (ack_a != 0) n_ack++; end
        check("mr_no_ack", n_ack, 0);
        rstb = 1'b1;
        step();
        check("mr_regrant_gid",  gid_a, 1);
        check("mr_regrant_ena",  ena_a, 1);
        check("mr_regrant_dout", dout_a, 32'h3C);
        for (int c = 0; c < 6; c++) begin
            step();
            req = req & ~ack_a;
        end
        drain();

        // Randomized traffic against the model, with occasional resets
        tag = "random";
        for (int c = 0; c < 500; c++) begin
            req      = N'($urandom_range(0, 3));
            req_data = (N*W)'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rstb = 1'b0;
                #1;
                model_reset();
                step();
                rstb = 1'b1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if anything above stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
